// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - Shared constants and FSM encoding for the LFSR burst generator
package lfsr_pkg;

  localparam logic [31:0] LFSR_DEF_TAPS = 32'h088C8892;
  localparam logic [31:0] LFSR_DEF_SEED = 32'h00BAD1C4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - Combinational STEPS-fold Fibonacci LFSR shift
module lfsr_step #(
  parameter int              WIDTH = 32,
  parameter int              STEPS = 1,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h088C8892)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state_i;
    for (int i = 0; i < STEPS; i++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    state_o = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Burst LFSR word generator with valid/ready output handshake
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEF_SEED),
  parameter int               CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lockup_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [0:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] step_out;
  logic             run;

  lfsr_step #(
    .WIDTH(WIDTH),
    .STEPS(STEPS),
    .TAPS (TAPS)
  ) u_step (
    .state_i(state_q),
    .state_o(step_out)
  );

  assign run = (fsm_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    fsm_d    = fsm_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    lockup_d = lockup_q;
    if (!run) begin
      // Load is applied before start so a combined strobe bursts from seed_i.
      if (load_i) begin
        if (seed_i == '0) begin
          state_d  = SEED;
          lockup_d = 1'b1;
        end else begin
          state_d  = seed_i;
          lockup_d = 1'b0;
        end
      end
      if (start_i) begin
        if (len_i != '0) begin
          rem_d = len_i;
          fsm_d = ST_RUN;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (abort_i) begin
      fsm_d = ST_IDLE;
      rem_d = '0;
    end else if (ready_i) begin
      // An all-zero state would stick forever, so fall back to the seed.
      if (step_out == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = step_out;
      end
      cnt_d = cnt_q + CNT_W'(1);
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        fsm_d  = ST_IDLE;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= SEED;
      fsm_q    <= ST_IDLE;
      rem_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fsm_q    <= fsm_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign data_o   = state_q;
  assign valid_o  = run;
  assign busy_o   = run;
  assign done_o   = done_q;
  assign lockup_o = lockup_q;
  assign count_o  = cnt_q;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the state and output width (legal 4..64).
REQ-002 The block SHALL have parameter STEPS, default 1, giving the single-bit shifts applied per advance (legal 1..WIDTH).
REQ-003 The block SHALL have parameter TAPS, default 32'h088C8892, giving the feedback tap mask (WIDTH bits).
REQ-004 The block SHALL have parameter SEED, default 32'h00BAD1C4, giving the reset and recovery state; it must be nonzero.
REQ-005 The block SHALL have parameter CNT_W, default 16, giving the burst length and counter width.
REQ-006 The block SHALL have the following ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- load_i  in  1  seed load strobe.
- seed_i  in  WIDTH  seed value.
- start_i  in  1  burst start strobe.
- len_i  in  CNT_W  burst length in words.
- abort_i  in  1  burst abort.
- data_o  out  WIDTH  current LFSR word.
- valid_o  out  1  data_o valid.
- ready_i  in  1  consumer accepts data_o.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle burst-complete pulse.
- lockup_o  out  1  sticky zero-state recovery flag.
- count_o  out  CNT_W  total accepted words, wraps.

Function
REQ-007 One step SHALL compute s' = {s[WIDTH-2:0], XOR-reduce(s & TAPS)}.
REQ-008 One advance SHALL apply STEPS consecutive steps within a single cycle.
REQ-009 data_o SHALL always equal the state register, combinationally.
REQ-010 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-011 In IDLE, valid_o and busy_o SHALL be 0 and the state SHALL NOT advance.
REQ-012 In IDLE, start_i with len_i != 0 SHALL load the remaining counter with len_i and enter RUN on the next cycle.
REQ-013 In IDLE, start_i with len_i == 0 SHALL stay in IDLE and pulse done_o in the next cycle.
REQ-014 In RUN, valid_o and busy_o SHALL be 1.
REQ-015 In RUN, each cycle with valid_o & ready_i SHALL advance the state once, decrement the remaining counter and increment count_o; with ready_i low, data_o SHALL be held stable.
REQ-016 The handshake that consumes the last word (remaining == 1) SHALL return the FSM to IDLE and pulse done_o for exactly one cycle.
REQ-017 abort_i in RUN SHALL return the FSM to IDLE on the next edge, with no done_o.
REQ-018 abort_i has priority over a same-cycle handshake: the state SHALL NOT advance and count_o SHALL NOT increment.
REQ-019 start_i in RUN SHALL be ignored.
REQ-020 load_i in IDLE SHALL load seed_i into the state and clear lockup_o.
REQ-021 load_i in RUN SHALL be ignored.
REQ-022 load_i and start_i together in IDLE SHALL both take effect; the first burst word is seed_i.
REQ-023 A zero seed_i on load, or an advance whose result is all-zero, SHALL substitute SEED and set lockup_o.
REQ-024 lockup_o SHALL remain set until reset or the next valid load.
REQ-025 count_o SHALL wrap from 2^CNT_W-1 to 0 and is never cleared except by reset.
REQ-026 The state SHALL be preserved across burst end and abort; the next burst continues the sequence.

Reset
REQ-027 Asserting reset_i SHALL immediately set: state = SEED, FSM = IDLE, remaining = 0, count_o = 0, done_o = 0, lockup_o = 0, valid_o = 0, busy_o = 0.
REQ-028 Reset asserted mid-burst SHALL discard the burst without a done_o pulse.
REQ-029 No output SHALL depend on clock edges while reset_i is high.

Structure
REQ-030 The default TAPS and SEED constants and the FSM state enumeration SHALL live in shared package lfsr_pkg.
REQ-031 The STEPS-fold step function SHALL be a combinational sub-module lfsr_step (parameters WIDTH, STEPS, TAPS), instantiated once.

Verification
REQ-032 The bench SHALL cover the following directed scenarios with default parameters:
- Reset, then start_i with len_i = 2 and ready_i = 1 -> words 0x00BAD1C4, 0x0175A388; done_o pulses 1 cycle; count_o = 2.
- ready_i held low 3 cycles mid-burst -> data_o and valid_o stable; count_o unchanged.
- load_i with seed_i = 0 in IDLE -> state = 0x00BAD1C4, lockup_o = 1; then load_i with seed_i = 0x1 -> lockup_o = 0, data_o = 0x00000001.
- abort_i coincident with a handshake -> FSM enters IDLE, no advance, no done_o.
- start_i with len_i = 0 -> done_o pulse, valid_o never asserts.
- STEPS = 4 build -> each advance equals four STEPS = 1 advances (compare against a reference model).
